// File: rtl/ddr3_line_port.sv
// ddr3_line_port: turns 256-bit line reads/writes into two 128-bit BL8 bursts on the DDR3 app interface.
// Define DDR3_LINE_PORT_STATS_EN to build the completed-line counters; otherwise they read as 0.
module ddr3_line_port #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int BEAT_ADDR_STEP = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [28:0]               ctrl_addr_i,
  input  logic [255:0]              ctrl_data_i,
  output logic [255:0]              ctrl_data_o,
  input  logic                      ctrl_we_i,
  input  logic                      ctrl_rd_i,
  output logic                      ctrl_ack_o,
  input  logic                      init_calib_complete,
  output logic [APP_ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [127:0]              app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [15:0]               app_wdf_mask,
  input  logic                      app_wdf_rdy,
  input  logic [127:0]              app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic [31:0]               stat_rd_cnt,
  output logic [31:0]               stat_wr_cnt
);
  typedef enum logic [2:0] {S_CALIB, S_INIT_ACK, S_IDLE, S_WRITE, S_READ, S_ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] cmd_cnt_q, cmd_cnt_d, wdf_cnt_q, wdf_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [255:0] data_q, data_d, rdata_q, rdata_d;
  logic calib_q, busy, cmd_hs, wdf_hs, rd_hs, idle_go, unused_ok;
  assign busy = state_q == S_WRITE || state_q == S_READ;
  assign cmd_hs = app_en && app_rdy;
  assign wdf_hs = app_wdf_wren && app_wdf_rdy;
  assign rd_hs = state_q == S_READ && app_rd_data_valid && rd_cnt_q != 2'd2;
  assign idle_go = state_q == S_IDLE && (ctrl_we_i || ctrl_rd_i);
  assign unused_ok = ^ctrl_addr_i[4:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CALIB;
      calib_q   <= 1'b0;
      cmd_cnt_q <= 2'd0;
      wdf_cnt_q <= 2'd0;
      rd_cnt_q  <= 2'd0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      calib_q   <= init_calib_complete;
      cmd_cnt_q <= cmd_cnt_d;
      wdf_cnt_q <= wdf_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CALIB:           state_d = calib_q ? S_INIT_ACK : S_CALIB;
      S_INIT_ACK, S_ACK: state_d = S_IDLE;
      S_IDLE:            state_d = ctrl_we_i ? S_WRITE : ctrl_rd_i ? S_READ : S_IDLE;
      S_WRITE:           state_d = (cmd_cnt_d == 2'd2 && wdf_cnt_d == 2'd2) ? S_ACK : S_WRITE;
      S_READ:            state_d = rd_cnt_d == 2'd2 ? S_ACK : S_READ;
      default:           state_d = S_CALIB;
    endcase
  end
  // Beat 0 of a read parks in the low half of the write buffer until beat 1 completes the line.
  always_comb begin
    cmd_cnt_d = busy ? cmd_cnt_q + {1'b0, cmd_hs} : 2'd0;
    wdf_cnt_d = state_q == S_WRITE ? wdf_cnt_q + {1'b0, wdf_hs} : 2'd0;
    rd_cnt_d  = state_q == S_READ ? rd_cnt_q + {1'b0, rd_hs} : 2'd0;
    addr_d    = idle_go ? APP_ADDR_WIDTH'({ctrl_addr_i[28:5], 4'b0000}) : addr_q;
    data_d    = (state_q == S_IDLE && ctrl_we_i) ? ctrl_data_i :
                (rd_hs && !rd_cnt_q[0]) ? {data_q[255:128], app_rd_data} : data_q;
    rdata_d   = (rd_hs && rd_cnt_q[0]) ? {app_rd_data, data_q[127:0]} : rdata_q;
  end
  always_comb begin
    app_en       = busy && cmd_cnt_q != 2'd2;
    app_cmd      = state_q == S_READ ? 3'b001 : 3'b000;
    app_addr     = addr_q + (cmd_cnt_q[0] ? APP_ADDR_WIDTH'(BEAT_ADDR_STEP) : '0);
    app_wdf_wren = state_q == S_WRITE && wdf_cnt_q != 2'd2;
    app_wdf_end  = app_wdf_wren;
    app_wdf_data = wdf_cnt_q[0] ? data_q[255:128] : data_q[127:0];
    ctrl_ack_o   = state_q == S_INIT_ACK || state_q == S_ACK;
  end
  assign app_wdf_mask = '0;
  assign ctrl_data_o  = rdata_q;
`ifdef DDR3_LINE_PORT_STATS_EN
  logic is_wr_q;
  logic [31:0] wr_lines_q, rd_lines_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q    <= 1'b0;
      wr_lines_q <= '0;
      rd_lines_q <= '0;
    end else begin
      if (idle_go) is_wr_q <= ctrl_we_i;
      if (state_q == S_ACK && is_wr_q) wr_lines_q <= wr_lines_q + 32'd1;
      if (state_q == S_ACK && !is_wr_q) rd_lines_q <= rd_lines_q + 32'd1;
    end
  end
  assign stat_wr_cnt = wr_lines_q;
  assign stat_rd_cnt = rd_lines_q;
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif
endmodule

// File: tb/tb_ddr3_line_port.sv
// tb_ddr3_line_port: directed and randomized line traffic against a line-level memory model and a DRAM responder.
module tb_ddr3_line_port;
  logic clk = 0, rst = 1;
  logic [28:0] ctrl_addr_i = '0;
  logic [255:0] ctrl_data_i = '0, ctrl_data_o;
  logic ctrl_we_i = 0, ctrl_rd_i = 0, ctrl_ack_o, init_calib_complete = 0;
  logic [27:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy = 1, app_wdf_wren, app_wdf_end, app_wdf_rdy = 1, app_rd_data_valid = 0;
  logic [127:0] app_wdf_data, app_rd_data = '0;
  logic [15:0] app_wdf_mask;
  logic [31:0] stat_rd_cnt, stat_wr_cnt;
  int vec = 0, errs = 0, nwr = 0, nrd = 0;
  logic [127:0] mem [logic [27:0]];
  logic [255:0] lines [logic [23:0]];

  ddr3_line_port dut (
    .clk(clk), .rst(rst), .ctrl_addr_i(ctrl_addr_i), .ctrl_data_i(ctrl_data_i), .ctrl_data_o(ctrl_data_o),
    .ctrl_we_i(ctrl_we_i), .ctrl_rd_i(ctrl_rd_i), .ctrl_ack_o(ctrl_ack_o),
    .init_calib_complete(init_calib_complete), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats;
`ifdef DDR3_LINE_PORT_STATS_EN
    chk("stat_wr", stat_wr_cnt, nwr);
    chk("stat_rd", stat_rd_cnt, nrd);
`else
    chk("stat_wr", stat_wr_cnt, 0);
    chk("stat_rd", stat_rd_cnt, 0);
`endif
  endtask

  function automatic logic [127:0] beat_of(input logic [27:0] x);
    return mem.exists(x) ? mem[x] : {100'b0, x};
  endfunction

  // What a read of this line must return: last written line, or the untouched DRAM pattern.
  function automatic logic [255:0] line_of(input logic [28:0] a);
    logic [27:0] b = {a[28:5], 4'b0000};
    return lines.exists(a[28:5]) ? lines[a[28:5]] : {100'b0, b + 28'd8, 100'b0, b};
  endfunction

  task automatic do_wr(input logic [28:0] a, input logic [255:0] d, input int stall, input bit rnd,
                       output int n, output int c_first);
    int c = 0, w = 0;
    logic [27:0] b = {a[28:5], 4'b0000};
    logic [27:0] cq[$];
    logic [127:0] dq[$];
    n = 0;
    c_first = -1;
    ctrl_addr_i = a;
    ctrl_data_i = d;
    ctrl_we_i = 1;
    tick;
    while (!ctrl_ack_o && n < 300) begin
      app_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = (n >= stall) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (app_en) begin
        chk("wr_cmd", app_cmd, 3'b000);
        chk("wr_addr", app_addr, b + 28'(8 * c));
      end
      if (app_en && app_rdy) begin
        cq.push_back(app_addr);
        c++;
      end
      if (app_wdf_wren) begin
        chk("wr_data", app_wdf_data, d[w*128 +: 128]);
        chk("wr_end", app_wdf_end, 1);
        chk("wr_mask", app_wdf_mask, 0);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (c_first < 0) c_first = c;
        dq.push_back(app_wdf_data);
        w++;
      end
      tick;
      n++;
    end
    chk("wr_ack", ctrl_ack_o, 1);
    chk("wr_cmds", c, 2);
    chk("wr_beats", w, 2);
    for (int i = 0; i < cq.size() && i < dq.size(); i++) mem[cq[i]] = dq[i];
    lines[a[28:5]] = d;
    nwr++;
    ctrl_we_i = 0;
    app_rdy = 1;
    app_wdf_rdy = 1;
  endtask

  task automatic do_rd(input logic [28:0] a, input int lat, input bit rnd, output int n, output int first_en);
    int c = 0, r = 0;
    logic [27:0] b = {a[28:5], 4'b0000};
    logic [27:0] pq[$];
    n = 0;
    first_en = -1;
    ctrl_addr_i = a;
    ctrl_rd_i = 1;
    tick;
    while (!ctrl_ack_o && n < 300) begin
      app_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      app_rd_data_valid = 0;
      if (pq.size() > 0 && n >= lat && !(rnd && $urandom_range(0, 1) == 0)) begin
        app_rd_data_valid = 1;
        app_rd_data = beat_of(pq.pop_front());
        r++;
      end
      if (app_en) begin
        if (first_en < 0) first_en = n;
        chk("rd_cmd", app_cmd, 3'b001);
        chk("rd_addr", app_addr, b + 28'(8 * c));
      end
      if (app_en && app_rdy) begin
        pq.push_back(app_addr);
        c++;
      end
      tick;
      n++;
    end
    app_rd_data_valid = 0;
    chk("rd_ack", ctrl_ack_o, 1);
    chk("rd_cmds", c, 2);
    chk("rd_beats", r, 2);
    chk("rd_data", ctrl_data_o, line_of(a));
    nrd++;
    ctrl_rd_i = 0;
    app_rdy = 1;
  endtask

  initial begin
    int n, f;
    logic [255:0] ab = {{32{4'hB}}, {32{4'hA}}};
    repeat (3) tick;
    chk("rst_ack", ctrl_ack_o, 0);
    chk("rst_data", ctrl_data_o, 0);
    chk("rst_en", app_en, 0);
    chk("rst_cmd", app_cmd, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_wdf", {app_wdf_wren, app_wdf_end}, 0);
    chk("rst_wdata", app_wdf_data, 0);
    chk_stats;
    rst = 0;
    repeat (9) begin
      tick;
      chk("calib_wait_ack", ctrl_ack_o, 0);
    end
    init_calib_complete = 1;
    tick;
    chk("init_ack_early", ctrl_ack_o, 0);
    tick;
    chk("init_ack", ctrl_ack_o, 1);
    repeat (5) begin
      tick;
      chk("init_ack_once", ctrl_ack_o, 0);
    end
    do_wr(29'h0000_1020, ab, 0, 0, n, f);
    chk("wr_latency", n, 2);
    tick;
    chk("wr_ack_pulse", ctrl_ack_o, 0);
    chk_stats;
    do_rd(29'h0000_1020, 20, 0, n, f);
    chk("rd_latency", n, 22);
    chk("rd_first_cmd", f, 0);
    tick;
    chk("rd_ack_pulse", ctrl_ack_o, 0);
    chk("rd_data_hold", ctrl_data_o, ab);
    chk_stats;
    do_wr(29'h0000_2040, {8{32'h1234_5678}} ^ ab, 5, 0, n, f);
    chk("stall_cmds_first", f, 2);
    chk("stall_latency", n, 7);
    tick;
    chk("stall_ack_pulse", ctrl_ack_o, 0);
    do_wr(29'h0000_3060, {8{$urandom()}}, 0, 0, n, f);
    do_rd(29'h0000_1020, 3, 0, n, f);
    chk("wb_refill_no_gap", f, 1);
    tick;
    chk_stats;
    for (int i = 0; i < 40; i++) begin
      logic [28:0] a = {13'h0, 11'(16 + $urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 1) == 1) do_wr(a, {8{$urandom()}}, $urandom_range(0, 3), 1, n, f);
      else do_rd(a, $urandom_range(0, 4), 1, n, f);
      tick;
      chk("rand_ack_pulse", ctrl_ack_o, 0);
      chk_stats;
    end
    ctrl_addr_i = 29'h0000_1020;
    ctrl_rd_i = 1;
    tick;
    tick;
    app_rd_data_valid = 1;
    app_rd_data = {4{32'hDEAD_BEEF}};
    tick;
    app_rd_data_valid = 0;
    ctrl_rd_i = 0;
    rst = 1;
    tick;
    chk("midrst_ack", ctrl_ack_o, 0);
    chk("midrst_en", app_en, 0);
    chk("midrst_data", ctrl_data_o, 0);
    rst = 0;
    nwr = 0;
    nrd = 0;
    app_rd_data_valid = 1;
    tick;
    app_rd_data_valid = 0;
    chk("late_beat_ack", ctrl_ack_o, 0);
    tick;
    chk("reinit_ack", ctrl_ack_o, 1);
    tick;
    chk("reinit_ack_once", ctrl_ack_o, 0);
    chk_stats;
    do_rd(29'h0000_1020, 2, 0, n, f);
    tick;
    chk_stats;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
